// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU; one op in flight at a time.
// Optional build macro ALU_ARB_TIMEOUT_EN adds a BUSY watchdog that returns an error response.
module alu_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_complete
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_lastGrant;
    logic        r_settle;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_sel;
    logic        r_rspValid;
    logic        r_rspId;
    logic [31:0] r_rspData;
    logic        r_rspZero;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_done;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_timeoutCnt;
    logic          r_rspErr;
    assign rsp_err = r_rspErr;
`else
    // Without the watchdog an error response is impossible; the parameter is inert here.
    assign rsp_err = (TIMEOUT_CYCLES < 0);
`endif

    // On a tie the requester that did not win the last accept gets the grant.
    assign w_idle     = (r_state == IDLE);
    assign w_grant0   = w_idle && req0_valid && (!req1_valid || r_lastGrant);
    assign w_grant1   = w_idle && req1_valid && (!req0_valid || !r_lastGrant);
    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // The first BUSY cycle lets the ALU see fresh operands, so a stale complete is ignored.
    assign w_done = !r_settle && alu_complete;

    assign rsp_valid = r_rspValid;
    assign rsp_id    = r_rspId;
    assign rsp_data  = r_rspData;
    assign rsp_zero  = r_rspZero;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_sel   = r_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_settle    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_rspValid  <= 1'b0;
            r_rspId     <= 1'b0;
            r_rspData   <= '0;
            r_rspZero   <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_rspErr     <= 1'b0;
            r_timeoutCnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_a         <= w_grant1 ? req1_a   : req0_a;
                        r_b         <= w_grant1 ? req1_b   : req0_b;
                        r_sel       <= w_grant1 ? req1_sel : req0_sel;
                        r_rspId     <= w_grant1;
                        r_lastGrant <= w_grant1;
                        r_settle    <= 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
                        r_timeoutCnt <= '0;
`endif
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    r_settle <= 1'b0;
                    if (w_done) begin
                        r_rspData  <= alu_out;
                        r_rspZero  <= alu_zero;
                        r_rspValid <= 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
                        r_rspErr   <= 1'b0;
`endif
                        r_state    <= RESP;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (r_timeoutCnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_rspData  <= '0;
                        r_rspZero  <= 1'b0;
                        r_rspErr   <= 1'b1;
                        r_rspValid <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_timeoutCnt <= r_timeoutCnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_rspValid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule
